// File: rtl/rv32i_rd_arbiter.sv
// Shares the base-register write port between writeback (priority) and the MDU.
// MDU results wait in a small FIFO. Define RV32I_ARB_BYPASS_EN to let an MDU result use an idle port in the same cycle.
module rv32i_rd_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wb_wr_rd,
    input  logic [4:0]  i_wb_rd_addr,
    input  logic [31:0] i_wb_rd,
    input  logic        i_mdu_valid,
    output logic        o_mdu_ready,
    input  logic [4:0]  i_mdu_rd_addr,
    input  logic [31:0] i_mdu_rd,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    output logic        o_wr_rd,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rd,
    output logic        o_stall,
    output logic        o_hazard
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [PW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DEPTH-1:0][4:0]  mem_addr_q;
    logic [DEPTH-1:0][31:0] mem_data_q;

    logic full, empty, wb_req, bypass, enq, deq, haz;
    logic [DEPTH-1:0][PW-1:0] off;
    logic [DEPTH-1:0]         ent_vld;

    assign full   = (cnt_q == CW'(DEPTH));
    assign empty  = (cnt_q == '0);
    assign wb_req = i_wb_wr_rd && (i_wb_rd_addr != 5'd0);

`ifdef RV32I_ARB_BYPASS_EN
    assign bypass = !i_rst && empty && !wb_req && i_mdu_valid && (i_mdu_rd_addr != 5'd0);
`else
    assign bypass = 1'b0;
`endif

    // x0 results are acknowledged but never stored.
    assign enq = !i_rst && i_mdu_valid && !full && (i_mdu_rd_addr != 5'd0) && !bypass;
    assign deq = !i_rst && (full || (!wb_req && !empty));

    assign rd_ptr_d = rd_ptr_q + PW'(deq);
    assign wr_ptr_d = wr_ptr_q + PW'(enq);
    assign cnt_d    = cnt_q + CW'(enq) - CW'(deq);

    // Slot i is live when its distance from the head is below the count.
    always_comb begin
        haz = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            off[i]     = PW'(i) - rd_ptr_q;
            ent_vld[i] = ({1'b0, off[i]} < cnt_q);
            if (ent_vld[i] && (mem_addr_q[i] != 5'd0) &&
                ((mem_addr_q[i] == i_rs1_addr) || (mem_addr_q[i] == i_rs2_addr) ||
                 (i_wb_wr_rd && (mem_addr_q[i] == i_wb_rd_addr))))
                haz = 1'b1;
        end
    end

    always_comb begin
        o_wr_rd   = 1'b0;
        o_rd_addr = 5'd0;
        o_rd      = 32'd0;
        if (!i_rst) begin
            if (full || (!wb_req && !empty)) begin
                o_wr_rd   = 1'b1;
                o_rd_addr = mem_addr_q[rd_ptr_q];
                o_rd      = mem_data_q[rd_ptr_q];
            end else if (wb_req) begin
                o_wr_rd   = 1'b1;
                o_rd_addr = i_wb_rd_addr;
                o_rd      = i_wb_rd;
            end else if (bypass) begin
                o_wr_rd   = 1'b1;
                o_rd_addr = i_mdu_rd_addr;
                o_rd      = i_mdu_rd;
            end
        end
    end

    assign o_stall     = !i_rst && full;
    assign o_mdu_ready = i_rst || !full;
    assign o_hazard    = !i_rst && haz;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            if (enq) begin
                mem_addr_q[wr_ptr_q] <= i_mdu_rd_addr;
                mem_data_q[wr_ptr_q] <= i_mdu_rd;
            end
        end
    end
endmodule

// File: tb/tb_rv32i_rd_arbiter.sv
// Self-checking bench for rv32i_rd_arbiter: directed vector table, hand sequences, random vs queue model.
module tb_rv32i_rd_arbiter;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_wr;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        mdu_v;
    logic        mdu_rdy;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic [4:0]  rs1, rs2;
    logic        wr;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        stall, hazard;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv32i_rd_arbiter #(.DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_wb_wr_rd(wb_wr), .i_wb_rd_addr(wb_addr), .i_wb_rd(wb_data),
        .i_mdu_valid(mdu_v), .o_mdu_ready(mdu_rdy),
        .i_mdu_rd_addr(mdu_addr), .i_mdu_rd(mdu_data),
        .i_rs1_addr(rs1), .i_rs2_addr(rs2),
        .o_wr_rd(wr), .o_rd_addr(rd_addr), .o_rd(rd_data),
        .o_stall(stall), .o_hazard(hazard)
    );

    typedef struct {
        logic rst, wbw; logic [4:0] wba; logic [31:0] wbd;
        logic mv; logic [4:0] ma; logic [31:0] md; logic [4:0] rs1, rs2;
        logic ewr; logic [4:0] ea; logic [31:0] ed; logic est, ehz, erdy;
    } vec_t;

    function automatic vec_t mk(logic r, logic ww, logic [4:0] wa, logic [31:0] wd,
                                logic v, logic [4:0] a, logic [31:0] d, logic [4:0] s1, logic [4:0] s2,
                                logic ewr, logic [4:0] ea, logic [31:0] ed, logic est, logic ehz, logic erdy);
        vec_t t;
        t.rst = r; t.wbw = ww; t.wba = wa; t.wbd = wd; t.mv = v; t.ma = a; t.md = d;
        t.rs1 = s1; t.rs2 = s2; t.ewr = ewr; t.ea = ea; t.ed = ed; t.est = est; t.ehz = ehz; t.erdy = erdy;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(logic r, logic ww, logic [4:0] wa, logic [31:0] wd,
                         logic v, logic [4:0] a, logic [31:0] d, logic [4:0] s1, logic [4:0] s2);
        rst = r; wb_wr = ww; wb_addr = wa; wb_data = wd;
        mdu_v = v; mdu_addr = a; mdu_data = d; rs1 = s1; rs2 = s2;
    endtask

    task automatic check_out(string tag, logic ewr, logic [4:0] ea, logic [31:0] ed,
                             logic est, logic ehz, logic erdy);
        chk({tag, ".wr"},     32'(wr),      32'(ewr));
        chk({tag, ".addr"},   32'(rd_addr), 32'(ea));
        chk({tag, ".data"},   rd_data,      ed);
        chk({tag, ".stall"},  32'(stall),   32'(est));
        chk({tag, ".hazard"}, 32'(hazard),  32'(ehz));
        chk({tag, ".ready"},  32'(mdu_rdy), 32'(erdy));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: parked results as an ordered list of {addr, data}.
    logic [36:0] mq[$];

    task automatic model_expect(output logic ewr, output logic [4:0] ea, output logic [31:0] ed,
                                output logic est, output logic ehz, output logic erdy);
        logic busy_wb, by;
        ewr = 0; ea = 0; ed = 0; est = 0; ehz = 0; erdy = 1;
        if (!rst) begin
            busy_wb = wb_wr && wb_addr != 0;
            by = 0;
`ifdef RV32I_ARB_BYPASS_EN
            by = (mq.size() == 0) && !busy_wb && mdu_v && mdu_addr != 0;
`endif
            est  = (mq.size() == DEPTH);
            erdy = !est;
            foreach (mq[i]) begin
                if (mq[i][36:32] != 0 && (mq[i][36:32] == rs1 || mq[i][36:32] == rs2 ||
                    (wb_wr && mq[i][36:32] == wb_addr)))
                    ehz = 1;
            end
            if (est || (!busy_wb && mq.size() > 0)) begin
                ewr = 1; ea = mq[0][36:32]; ed = mq[0][31:0];
            end else if (busy_wb) begin
                ewr = 1; ea = wb_addr; ed = wb_data;
            end else if (by) begin
                ewr = 1; ea = mdu_addr; ed = mdu_data;
            end
        end
    endtask

    task automatic model_update(input logic was_wr, input logic was_full);
        logic busy_wb, by;
        if (rst) begin
            mq.delete();
        end else begin
            busy_wb = wb_wr && wb_addr != 0;
            by = 0;
`ifdef RV32I_ARB_BYPASS_EN
            by = (mq.size() == 0) && !busy_wb && mdu_v && mdu_addr != 0;
`endif
            if (was_wr && (was_full || !busy_wb) && mq.size() > 0) void'(mq.pop_front());
            if (mdu_v && !was_full && mdu_addr != 0 && !by) mq.push_back({mdu_addr, mdu_data});
        end
    endtask

    vec_t vt[18];

    initial begin
        vt[0]  = mk(1,0,0,0,       1,5,32'hAA,0,0,   0,0,0,0,0,1);
        vt[1]  = mk(1,0,0,0,       1,5,32'hAA,0,0,   0,0,0,0,0,1);
        vt[2]  = mk(0,0,0,0,       0,0,0,0,0,        0,0,0,0,0,1);
        vt[3]  = mk(0,1,3,32'h11,  1,7,32'h22,0,0,   1,3,32'h11,0,0,1);
        vt[4]  = mk(0,1,3,32'h11,  1,8,32'h33,0,0,   1,3,32'h11,0,0,1);
        vt[5]  = mk(0,1,3,32'h11,  0,0,0,0,0,        1,7,32'h22,1,0,0);
        vt[6]  = mk(0,1,3,32'h11,  0,0,0,8,0,        1,3,32'h11,0,1,1);
        vt[7]  = mk(0,0,0,0,       0,0,0,8,0,        1,8,32'h33,0,1,1);
        vt[8]  = mk(0,0,0,0,       0,0,0,8,0,        0,0,0,0,0,1);
        vt[9]  = mk(0,1,0,32'h55,  1,0,32'h66,0,0,   0,0,0,0,0,1);
        vt[10] = mk(0,0,0,0,       0,0,0,0,0,        0,0,0,0,0,1);
        vt[11] = mk(0,1,3,32'h44,  1,9,32'h99,0,0,   1,3,32'h44,0,0,1);
        vt[12] = mk(0,1,9,32'h77,  0,0,0,0,0,        1,9,32'h77,0,1,1);
        vt[13] = mk(0,0,9,0,       0,0,0,0,9,        1,9,32'h99,0,1,1);
        vt[14] = mk(0,0,0,0,       0,0,0,0,9,        0,0,0,0,0,1);
        vt[15] = mk(0,1,3,32'h12,  1,10,32'hA0,0,0,  1,3,32'h12,0,0,1);
        vt[16] = mk(1,0,0,0,       0,0,0,10,0,       0,0,0,0,0,1);
        vt[17] = mk(0,0,0,0,       0,0,0,10,0,       0,0,0,0,0,1);

        // Directed table: one row per clock, state carries between rows.
        for (int i = 0; i < 18; i++) begin
            drive(vt[i].rst, vt[i].wbw, vt[i].wba, vt[i].wbd, vt[i].mv, vt[i].ma, vt[i].md,
                  vt[i].rs1, vt[i].rs2);
            @(negedge clk);
            check_out($sformatf("vec%0d", i), vt[i].ewr, vt[i].ea, vt[i].ed, vt[i].est, vt[i].ehz, vt[i].erdy);
            next_cycle();
        end

        // Idle-port MDU result to x5.
        drive(0,0,0,0, 1,5,32'hDEADBEEF, 5,0);
        @(negedge clk);
`ifdef RV32I_ARB_BYPASS_EN
        check_out("idle0", 1, 5, 32'hDEADBEEF, 0, 0, 1);
`else
        check_out("idle0", 0, 0, 0, 0, 0, 1);
`endif
        next_cycle();
        drive(0,0,0,0, 0,0,0, 5,0);
        @(negedge clk);
`ifdef RV32I_ARB_BYPASS_EN
        check_out("idle1", 0, 0, 0, 0, 0, 1);
`else
        check_out("idle1", 1, 5, 32'hDEADBEEF, 0, 1, 1);
`endif
        next_cycle();

        // Pointer wrap: five back-to-back MDU results, then drain.
        for (int k = 0; k < 7; k++) begin
            if (k < 5) drive(0,0,0,0, 1,5'(11+k),32'h100+k, 0,0);
            else       drive(0,0,0,0, 0,0,0, 0,0);
            @(negedge clk);
`ifdef RV32I_ARB_BYPASS_EN
            if (k < 5) check_out($sformatf("wrap%0d", k), 1, 5'(11+k), 32'h100+k, 0, 0, 1);
            else       check_out($sformatf("wrap%0d", k), 0, 0, 0, 0, 0, 1);
`else
            if (k >= 1 && k <= 5) check_out($sformatf("wrap%0d", k), 1, 5'(10+k), 32'h100+k-1, 0, 0, 1);
            else                  check_out($sformatf("wrap%0d", k), 0, 0, 0, 0, 0, 1);
`endif
            next_cycle();
        end

        // Random traffic against the queue model, following the hold rules of both producers.
        begin
            logic hold_wb, hold_mdu;
            logic ewr, est, ehz, erdy;
            logic [4:0] ea;
            logic [31:0] ed;
            hold_wb = 0; hold_mdu = 0;
            drive(1,0,0,0, 0,0,0, 0,0);
            for (int c = 0; c < 3000; c++) begin
                if (c > 0) begin
                    rst = ($urandom_range(0, 63) == 0);
                    if (!hold_wb) begin
                        wb_wr = $urandom_range(0, 1);
                        wb_addr = 5'($urandom_range(0, 7));
                        wb_data = $urandom;
                    end
                    if (!hold_mdu) begin
                        mdu_v = ($urandom_range(0, 2) == 0);
                        mdu_addr = 5'($urandom_range(0, 7));
                        mdu_data = $urandom;
                    end
                    rs1 = 5'($urandom_range(0, 7));
                    rs2 = 5'($urandom_range(0, 7));
                end
                @(negedge clk);
                model_expect(ewr, ea, ed, est, ehz, erdy);
                check_out($sformatf("rnd%0d", c), ewr, ea, ed, est, ehz, erdy);
                hold_wb  = !rst && est && wb_wr;
                hold_mdu = !rst && mdu_v && !erdy;
                model_update(ewr, est);
                next_cycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
